shared_mem_mport: RTL
=====================

Name: shared_mem_mport

Overview:
- N-port generalisation of the team's shared-memory dual-port RAM.
- Sits between the BN forward paths and the core backward paths in the shared-memory subsystem.
- Adds:
  - parametrised port count
  - byte-enable writes
  - a per-port request/valid handshake
  - selectable read latency
  - selectable same-address write-collision policy (fixed priority or round-robin)
  - per-port collision reporting

Parameters:
- NUM_PORTS, 4, number of ports (2..8).
- LOCAL_ADDR_WIDTH, 10, address width; depth = 2**LOCAL_ADDR_WIDTH.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- RD_LATENCY, 1, cycles from request to rvalid (1 or 2).
- COLLISION_MODE, 0, 0 = fixed priority (lowest port index wins); 1 = round-robin.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-port request strobe.
- we  in  NUM_PORTS  per-port write enable; qualified by req.
- addr  in  NUM_PORTS*LOCAL_ADDR_WIDTH  packed addresses; port p at slice p.
- wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
- be  in  NUM_PORTS*(DATA_WIDTH/8)  packed byte enables; bit b covers byte b.
- rdata  out  NUM_PORTS*DATA_WIDTH  packed registered read data.
- rvalid  out  NUM_PORTS  rdata for port p is valid.
- collision  out  NUM_PORTS  port p's write was dropped; aligned with rvalid.
- init_busy  out  1  memory clear in progress; constant 0 when SMEM_INIT_CLEAR_EN is undefined.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rdata, rvalid and collision are cleared to 0.
  - The round-robin pointer rr_ptr is set to 0.
  - In-flight pipeline entries are discarded, so no rvalid pulses after reset even for requests accepted the cycle before.
  - Memory contents are not reset unless the optional feature is enabled.
- Handshake:
  - Every req=1 is accepted in the cycle it is presented; there is no back-pressure.
  - Each accepted request produces exactly one rvalid pulse RD_LATENCY cycles later, for both reads and writes.
  - rdata holds its last value while rvalid=0.
- Write effect:
  - A granted write updates only the bytes with be=1, at the rising edge where req&we is sampled.
  - be=0 on all bytes is a legal no-op write; it still counts for collision and rvalid.
- Collision groups:
  - Ports with req&we=1 and equal addresses form a group; exactly one member of each group wins.
  - COLLISION_MODE=0: the lowest index in the group wins.
  - COLLISION_MODE=1: the first index at or after rr_ptr, in circular order, wins.
  - Losers write nothing and assert collision together with their rvalid.
  - There is no byte merging across ports, even when byte enables are disjoint.
- Round-robin pointer:
  - In any cycle with at least one collision group, rr_ptr <= (highest winner index among all groups + 1) mod NUM_PORTS.
  - Otherwise rr_ptr holds.
- Read data (write-first):
  - rdata[p] = mem[addr[p]] with the bytes of the winning same-address write overlaid by that write's wdata, where that winner's be=1.
  - This applies to the writer itself, to other readers of that address, and to collision losers.
  - With no write to the address, rdata[p] = the old memory word.
- Latency:
  - RD_LATENCY=1: rdata and rvalid are registered once.
  - RD_LATENCY=2: an additional output register stage is added.
  - Memory write timing is the same for both latencies.
  - A read issued one cycle after a write to the same address returns the new data for both latencies.
- Different addresses: all writes commit in the same cycle, with no interaction.
- Out-of-range parameters (NUM_PORTS<2, DATA_WIDTH%8!=0, RD_LATENCY not 1 or 2): elaboration-time error via a generate-block $error.

Optional Feature:
- Macro: SMEM_INIT_CLEAR_EN.
- Defined:
  - Leaving reset starts a clear FSM: IDLE -> CLEAR -> IDLE.
  - CLEAR writes 0 to one address per cycle, from 0 to depth-1, taking exactly 2**LOCAL_ADDR_WIDTH cycles.
  - init_busy=1 from the first cycle after reset deasserts until the last clear write.
  - While init_busy=1, req is ignored: no write, no rvalid, no collision.
  - Asserting rst during CLEAR restarts the clear from address 0.
- Undefined: there is no FSM, init_busy is tied to 0, and memory starts uninitialised.

Test Plan:
- Basic write then read, NUM_PORTS=4, RD_LATENCY=1:
  - Stimulus: port0 writes 0xDEADBEEF to 0x010 with be=4'hF; the next cycle port3 reads 0x010.
  - Response: port0 rvalid at +1 with rdata=0xDEADBEEF; port3 rdata=0xDEADBEEF at +1 after its read.
- Byte enables:
  - Stimulus: mem[0x020]=0x11223344; port1 writes 0xAABBCCDD with be=4'b0101; in the same cycle port2 reads 0x020.
  - Response: port1 and port2 rdata=0x11BB33DD; a later read returns 0x11BB33DD.
- Fixed priority:
  - Stimulus: COLLISION_MODE=0; ports 1, 2 and 3 write 0x1, 0x2, 0x3 to 0x005.
  - Response: mem=0x1; collision=4'b1100; all three rdata=0x1.
- Round-robin:
  - Stimulus: COLLISION_MODE=1; ports 0 and 2 write 0xA and 0xC to 0x007 for three consecutive cycles.
  - Response: winners are 0, 2, 0; rr_ptr goes 1, 3, 1; collision=4'b0100, 4'b0001, 4'b0100.
- Latency 2 and reset mid-flight:
  - Stimulus: RD_LATENCY=2; port0 reads at cycle t; rst=1 at t+1.
  - Response: no rvalid at t+2; all outputs 0.
- SMEM_INIT_CLEAR_EN, LOCAL_ADDR_WIDTH=4:
  - Stimulus: release rst; req held 1 throughout.
  - Response: init_busy=1 for 16 cycles with no rvalid; afterwards a read of any address returns 0.

Source files
------------

// File: rtl/shared_mem_mport.sv
// -----------------------------------------------------------------------------
// shared_mem_mport
//   N-port shared-memory RAM with byte-enable writes, a per-port req/rvalid
//   handshake, selectable read latency (1 or 2) and a selectable same-address
//   write-collision policy (fixed priority or round-robin).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        per-port request strobe (never back-pressured)
//   we         per-port write enable, qualified by req
//   addr       packed addresses, port p at [p*LOCAL_ADDR_WIDTH +: LOCAL_ADDR_WIDTH]
//   wdata      packed write data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   be         packed byte enables, port p at [p*(DATA_WIDTH/8) +: DATA_WIDTH/8]
//   rdata      packed registered read data (write-first), held while rvalid=0
//   rvalid     one pulse per accepted request, RD_LATENCY cycles later
//   collision  port's write lost a same-address collision; aligned with rvalid
//   init_busy  memory clear in progress
//
// Optional feature: define SMEM_INIT_CLEAR_EN to zero the whole memory after
// every reset (one address per cycle); requests are ignored while it runs.
// Without it init_busy is tied to 0 and the memory starts uninitialised.
// -----------------------------------------------------------------------------
module shared_mem_mport #(
  parameter int NUM_PORTS        = 4,
  parameter int LOCAL_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int RD_LATENCY       = 1,
  parameter int COLLISION_MODE   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   req,
  input  logic [NUM_PORTS-1:0]                   we,
  input  logic [NUM_PORTS*LOCAL_ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]    be,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]        rdata,
  output logic [NUM_PORTS-1:0]                   rvalid,
  output logic [NUM_PORTS-1:0]                   collision,
  output logic                                   init_busy
);

  localparam int AW    = LOCAL_ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int BW    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** AW;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
    $error("shared_mem_mport: NUM_PORTS must be 2..8");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("shared_mem_mport: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
    $error("shared_mem_mport: RD_LATENCY must be 1 or 2");
  end

  logic [DW-1:0]                mem_q [DEPTH];
  logic [AW-1:0]                addr_a  [NUM_PORTS];
  logic [DW-1:0]                wdata_a [NUM_PORTS];
  logic [BW-1:0]                be_a    [NUM_PORTS];
  logic [NUM_PORTS-1:0]         acc, wr, lose, win;
  logic [NUM_PORTS-1:0][DW-1:0] rd_word;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0][DW-1:0] s1_data_q, s1_data_d;
  logic [NUM_PORTS-1:0]         s1_valid_q, s1_valid_d;
  logic [NUM_PORTS-1:0]         s1_coll_q, s1_coll_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_a[p]  = addr[p*AW +: AW];
      wdata_a[p] = wdata[p*DW +: DW];
      be_a[p]    = be[p*BW +: BW];
    end
  end

  assign acc = init_busy ? '0 : req;
  assign wr  = acc & we;

  // A writer loses when another writer to the same address ranks ahead of it:
  // lower index in fixed mode, smaller circular distance from rr_ptr otherwise.
  always_comb begin
    lose = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && wr[p] && wr[q] && addr_a[q] == addr_a[p]) begin
          if (COLLISION_MODE == 0) begin
            if (q < p) lose[p] = 1'b1;
          end else if (((q - int'(rr_ptr_q) + NUM_PORTS) % NUM_PORTS) <
                       ((p - int'(rr_ptr_q) + NUM_PORTS) % NUM_PORTS)) begin
            lose[p] = 1'b1;
          end
        end
      end
    end
  end

  assign win = wr & ~lose;

  // The pointer only moves past the highest winner of a real collision group.
  always_comb begin
    int hi;
    hi       = 0;
    rr_ptr_d = rr_ptr_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (win[p] && lose[q] && addr_a[q] == addr_a[p]) hi = p;
      end
    end
    if (|lose) rr_ptr_d = PTR_W'((hi + 1) % NUM_PORTS);
  end

  // Write-first read: old word with the winning same-address write overlaid.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word[p] = mem_q[addr_a[p]];
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (win[q] && addr_a[q] == addr_a[p]) begin
          for (int b = 0; b < BW; b++) begin
            if (be_a[q][b]) rd_word[p][b*8 +: 8] = wdata_a[q][b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    s1_data_d = s1_data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (acc[p]) s1_data_d[p] = rd_word[p];
    end
    s1_valid_d = acc;
    s1_coll_d  = lose;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      s1_data_q  <= '0;
      s1_valid_q <= '0;
      s1_coll_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      s1_coll_q  <= s1_coll_d;
    end
  end

`ifdef SMEM_INIT_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;
  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Busy only once reset has been released; a reset during CLEAR restarts it.
  assign init_busy = (state_q == ST_CLEAR) && !rst;
`else
  assign init_busy = 1'b0;
`endif

  // NOTE: the storage array has no reset branch; clearing it in one cycle would
  // need a flop-based array, so the contents are only defined once written.
  always_ff @(posedge clk) begin
`ifdef SMEM_INIT_CLEAR_EN
    if (init_busy) mem_q[clr_addr_q] <= '0;
`endif
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (win[p]) begin
        for (int b = 0; b < BW; b++) begin
          if (be_a[p][b]) mem_q[addr_a[p]][b*8 +: 8] <= wdata_a[p][b*8 +: 8];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [NUM_PORTS-1:0][DW-1:0] s2_data_q, s2_data_d;
    logic [NUM_PORTS-1:0]         s2_valid_q, s2_coll_q;

    always_comb begin
      s2_data_d = s2_data_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (s1_valid_q[p]) s2_data_d[p] = s1_data_q[p];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= '0;
        s2_coll_q  <= '0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s1_valid_q;
        s2_coll_q  <= s1_coll_q;
      end
    end

    assign rdata     = s2_data_q;
    assign rvalid    = s2_valid_q;
    assign collision = s2_coll_q;
  end else begin : g_lat1
    assign rdata     = s1_data_q;
    assign rvalid    = s1_valid_q;
    assign collision = s1_coll_q;
  end

endmodule
